acl_cfg_writer: RTL and testbench
=================================

Name: acl_cfg_writer

Overview:
- Register-side initiator that programs the per-port ACL match table in the rx frame ACL manager.
- Accepts one item-load command plus a byte stream of compare data from the host/CPU register bridge.
- Drives the ACL item write interface in order: optional list clear, wait for ready, per-byte writes, result value, completion strobe.
- Sits between the switch register block and the rx MAC ACL table; one instance per switch.

Parameters:
PORT_NUM, 4, number of switch ports; width of the port-select vector
RDY_TIMEOUT, 1024, max cycles to wait for i_acl_list_rdy_regs before aborting with error

Ports:
i_clk  in  1  core clock, 250 MHz
i_rst  in  1  synchronous active-high reset
i_cfg_start  in  1  one-cycle command strobe, sampled only in IDLE
i_cfg_port_sel  in  PORT_NUM  target port(s), latched at start
i_cfg_clr  in  1  1 = clear the port's list before loading the item
i_cfg_item_sel  in  5  item index 0..31, latched at start
i_cfg_item_len  in  7  number of compare bytes, legal 1..64, latched at start
i_cfg_item_rslt  in  16  [7:0] frame type, [15:8] forward port; latched at start
i_cfg_byte  in  8  compare byte data
i_cfg_byte_valid  in  1  byte valid
o_cfg_byte_ready  out  1  byte accepted when valid & ready
o_cfg_busy  out  1  high from the cycle after an accepted start until return to IDLE
o_cfg_done  out  1  one-cycle pulse on successful completion
o_cfg_err  out  1  one-cycle pulse on illegal length or ready timeout
o_acl_port_sel  out  PORT_NUM  port select to ACL table
o_acl_clr_list_regs  out  1  one-cycle clear pulse
i_acl_list_rdy_regs  in  1  ACL table idle/ready
o_acl_item_sel_regs  out  5  item select
o_acl_item_waddr_regs  out  6  byte address within item
o_acl_item_din_regs  out  8  byte data
o_acl_item_we_regs  out  1  one-cycle write strobe per byte
o_acl_item_rslt_regs  out  16  result value
o_acl_item_complete_regs  out  1  one-cycle completion strobe

Behaviour:
- Single clock i_clk; i_rst synchronous, active-high. All outputs are registered.
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset mid-operation: return to IDLE next edge; no complete or done is issued. Partially written bytes stay in the ACL table.
- States: IDLE, CHECK, CLR, WAIT_RDY, WRITE, COMPLETE, DONE, ERR.
- IDLE: on i_cfg_start, latch port_sel/clr/item_sel/len/rslt, then go to CHECK. Start while not IDLE is ignored.
- CHECK:
  - len==0 or len>64: go to ERR; no ACL interface activity.
  - Otherwise go to CLR if clr=1, else WAIT_RDY.
- o_acl_port_sel, o_acl_item_sel_regs, o_acl_item_rslt_regs:
  - Driven from latched values from CHECK through COMPLETE.
  - Held stable for the whole operation.
  - Return to 0 in IDLE.
- CLR: o_acl_clr_list_regs=1 for exactly one cycle, then go to WAIT_RDY.
- WAIT_RDY:
  - Timeout counter starts at 0 on entry.
  - i_acl_list_rdy_regs=1: go to WRITE.
  - Counter reaches RDY_TIMEOUT-1 without ready: go to ERR.
  - The cycle immediately after CLR is a wait cycle; ready is not sampled there.
- WRITE:
  - o_cfg_byte_ready = 1 while byte_cnt < len; combinational from state/count; no dependency on valid.
  - Each handshake in cycle N gives, in cycle N+1: we=1, waddr=byte_cnt (first byte addr 0), din=byte; byte_cnt increments.
  - Back-to-back handshakes give back-to-back we pulses. Gaps in valid give no we.
  - When the handshake of byte len-1 occurs, ready drops the next cycle and the state goes to COMPLETE.
- COMPLETE: o_acl_item_complete_regs=1 for one cycle, exactly one cycle after the final we pulse; then go to DONE.
- DONE: o_cfg_done pulse one cycle; go to IDLE.
- ERR: o_cfg_err pulse one cycle; go to IDLE. No complete is issued.
- o_cfg_busy=1 in every state except IDLE.
- i_acl_list_rdy_regs is ignored outside WAIT_RDY.
- Widths: waddr = byte_cnt[5:0]. byte_cnt is 7 bits, so len=64 ends at byte_cnt 64 with no wrap.

Test Plan:
- Start, clr=0, port_sel=4'b0010, item=3, len=4, rslt=16'h0A11, bytes 11,22,33,44 streamed back-to-back, rdy=1 -> 4 consecutive we pulses, waddr 0..3 / din 11..44. Complete pulses 1 cycle after the last we, done 1 cycle later. No clr pulse; busy drops after done.
- clr=1, rdy held low 5 cycles after clr then high -> single clr pulse; no we until rdy seen; then normal writes and done.
- len=64 with valid toggling every other cycle -> 64 we pulses, waddr 0..63, each data byte matches; ready low after the 64th byte; complete, done.
- len=0, then separately len=65 -> err pulse within 2 cycles of start; no clr, we, or complete; busy low afterwards.
- rdy never asserted, RDY_TIMEOUT=16 -> err pulse after 16 WAIT_RDY cycles; no we or complete. Second start in IDLE proceeds normally.
- Reset asserted after 2 of 8 bytes written; a start issued while busy is ignored -> all outputs 0 next cycle, no complete or done. A subsequent start after reset runs a full sequence.

Source files
------------

// File: rtl/acl_cfg_writer.sv
`default_nettype none
// ============================================================================
// Module   : acl_cfg_writer
// Brief    : Loads one ACL match item (optional list clear, ready wait,
//            per-byte writes, result, completion strobe) from a host command.
// Revision : 1.0
// ============================================================================
module acl_cfg_writer #(
    parameter int PORT_NUM    = 4,
    parameter int RDY_TIMEOUT = 1024
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cfg_start,
    input  logic [PORT_NUM-1:0] i_cfg_port_sel,
    input  logic                i_cfg_clr,
    input  logic [4:0]          i_cfg_item_sel,
    input  logic [6:0]          i_cfg_item_len,
    input  logic [15:0]         i_cfg_item_rslt,
    input  logic [7:0]          i_cfg_byte,
    input  logic                i_cfg_byte_valid,
    output logic                o_cfg_byte_ready,
    output logic                o_cfg_busy,
    output logic                o_cfg_done,
    output logic                o_cfg_err,
    output logic [PORT_NUM-1:0] o_acl_port_sel,
    output logic                o_acl_clr_list_regs,
    input  logic                i_acl_list_rdy_regs,
    output logic [4:0]          o_acl_item_sel_regs,
    output logic [5:0]          o_acl_item_waddr_regs,
    output logic [7:0]          o_acl_item_din_regs,
    output logic                o_acl_item_we_regs,
    output logic [15:0]         o_acl_item_rslt_regs,
    output logic                o_acl_item_complete_regs
);

    localparam int              c_TMO_W    = (RDY_TIMEOUT > 1) ? $clog2(RDY_TIMEOUT + 1) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(RDY_TIMEOUT - 1);
    localparam logic [6:0]      c_MAX_LEN  = 7'd64;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_CLR      = 3'd2,
        S_WAIT_RDY = 3'd3,
        S_WRITE    = 3'd4,
        S_COMPLETE = 3'd5,
        S_DONE     = 3'd6,
        S_ERR      = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_clr_l;
    logic [6:0]            r_len;
    logic [6:0]            r_cnt;
    logic [c_TMO_W-1:0]    r_tmo;
    logic                  r_skip;
    logic                  w_byte_ready;
    logic                  w_hs;

    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_acl_clr;
    logic                  r_complete;
    logic                  r_we;
    logic [5:0]            r_waddr;
    logic [7:0]            r_din;
    logic [PORT_NUM-1:0]   r_port;
    logic [4:0]            r_item;
    logic [15:0]           r_rslt;

    assign w_byte_ready = (r_state == S_WRITE) && (r_cnt < r_len);
    assign w_hs         = w_byte_ready && i_cfg_byte_valid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (i_cfg_start) w_next = S_CHECK;
            S_CHECK: begin
                if ((r_len == 7'd0) || (r_len > c_MAX_LEN)) w_next = S_ERR;
                else if (r_clr_l)                           w_next = S_CLR;
                else                                        w_next = S_WAIT_RDY;
            end
            S_CLR:      w_next = S_WAIT_RDY;
            // The first wait cycle after a clear ignores ready: the table has
            // not yet had a chance to drop it in response to the clear.
            S_WAIT_RDY: begin
                if (!r_skip && i_acl_list_rdy_regs) w_next = S_WRITE;
                else if (r_tmo == c_TMO_LAST)       w_next = S_ERR;
            end
            S_WRITE:    if (r_cnt == r_len) w_next = S_COMPLETE;
            S_COMPLETE: w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            S_ERR:      w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_clr_l    <= 1'b0;
            r_len      <= 7'd0;
            r_cnt      <= 7'd0;
            r_tmo      <= '0;
            r_skip     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_acl_clr  <= 1'b0;
            r_complete <= 1'b0;
            r_we       <= 1'b0;
            r_waddr    <= 6'd0;
            r_din      <= 8'd0;
            r_port     <= '0;
            r_item     <= 5'd0;
            r_rslt     <= 16'd0;
        end else begin
            r_state    <= w_next;
            // Status pulses are registered from the next state so each lines
            // up exactly with the state it belongs to.
            r_busy     <= (w_next != S_IDLE);
            r_acl_clr  <= (w_next == S_CLR);
            r_complete <= (w_next == S_COMPLETE);
            r_done     <= (w_next == S_DONE);
            r_err      <= (w_next == S_ERR);
            r_we       <= w_hs;
            r_skip     <= (r_state == S_CLR);

            if (r_state == S_WAIT_RDY) r_tmo <= r_tmo + 1'b1;
            else                       r_tmo <= '0;

            if (w_hs) begin
                r_waddr <= r_cnt[5:0];
                r_din   <= i_cfg_byte;
                r_cnt   <= r_cnt + 7'd1;
            end

            if ((r_state == S_IDLE) && i_cfg_start) begin
                r_clr_l <= i_cfg_clr;
                r_len   <= i_cfg_item_len;
                r_cnt   <= 7'd0;
                r_port  <= i_cfg_port_sel;
                r_item  <= i_cfg_item_sel;
                r_rslt  <= i_cfg_item_rslt;
            end else if (w_next == S_IDLE) begin
                r_port  <= '0;
                r_item  <= 5'd0;
                r_rslt  <= 16'd0;
            end
        end
    end

    assign o_cfg_byte_ready         = w_byte_ready;
    assign o_cfg_busy               = r_busy;
    assign o_cfg_done               = r_done;
    assign o_cfg_err                = r_err;
    assign o_acl_port_sel           = r_port;
    assign o_acl_clr_list_regs      = r_acl_clr;
    assign o_acl_item_sel_regs      = r_item;
    assign o_acl_item_waddr_regs    = r_waddr;
    assign o_acl_item_din_regs      = r_din;
    assign o_acl_item_we_regs       = r_we;
    assign o_acl_item_rslt_regs     = r_rslt;
    assign o_acl_item_complete_regs = r_complete;

endmodule
`default_nettype wire

// File: tb/tb_acl_cfg_writer.sv
`default_nettype none
// Testbench for acl_cfg_writer: randomized item loads checked against a
// transaction-level model of the expected ACL write sequence.
module tb_acl_cfg_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  cfg_port = '0;
    logic        cfg_clr = 1'b0;
    logic [4:0]  cfg_item = '0;
    logic [6:0]  cfg_len = '0;
    logic [15:0] cfg_rslt = '0;
    logic [7:0]  byte_d = '0;
    logic        valid = 1'b0;
    logic        rdy = 1'b0;

    logic        o_cfg_byte_ready, o_cfg_busy, o_cfg_done, o_cfg_err;
    logic [3:0]  o_acl_port_sel;
    logic        o_acl_clr_list_regs, o_acl_item_we_regs, o_acl_item_complete_regs;
    logic [4:0]  o_acl_item_sel_regs;
    logic [5:0]  o_acl_item_waddr_regs;
    logic [7:0]  o_acl_item_din_regs;
    logic [15:0] o_acl_item_rslt_regs;

    acl_cfg_writer #(.PORT_NUM(4), .RDY_TIMEOUT(16)) dut (
        .i_clk                    (clk),
        .i_rst                    (rst),
        .i_cfg_start              (start),
        .i_cfg_port_sel           (cfg_port),
        .i_cfg_clr                (cfg_clr),
        .i_cfg_item_sel           (cfg_item),
        .i_cfg_item_len           (cfg_len),
        .i_cfg_item_rslt          (cfg_rslt),
        .i_cfg_byte               (byte_d),
        .i_cfg_byte_valid         (valid),
        .o_cfg_byte_ready         (o_cfg_byte_ready),
        .o_cfg_busy               (o_cfg_busy),
        .o_cfg_done               (o_cfg_done),
        .o_cfg_err                (o_cfg_err),
        .o_acl_port_sel           (o_acl_port_sel),
        .o_acl_clr_list_regs      (o_acl_clr_list_regs),
        .i_acl_list_rdy_regs      (rdy),
        .o_acl_item_sel_regs      (o_acl_item_sel_regs),
        .o_acl_item_waddr_regs    (o_acl_item_waddr_regs),
        .o_acl_item_din_regs      (o_acl_item_din_regs),
        .o_acl_item_we_regs       (o_acl_item_we_regs),
        .o_acl_item_rslt_regs     (o_acl_item_rslt_regs),
        .o_acl_item_complete_regs (o_acl_item_complete_regs)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation log, filled on the falling edge
    logic [5:0] we_a[$];
    logic [7:0] we_d[$];
    int         we_c[$];
    int         hs_c[$];
    logic [7:0] byte_q[$];
    logic [7:0] exp_q[$];
    int clr_n, cmp_n, done_n, err_n, sel_bad;
    int clr_c, cmp_c, done_c, err_c;
    int s0, rdy_first, rdy_rise;
    logic ready_after;
    logic [3:0]  e_port = '0;
    logic [4:0]  e_item = '0;
    logic [15:0] e_rslt = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_acl_item_we_regs) begin
                we_a.push_back(o_acl_item_waddr_regs);
                we_d.push_back(o_acl_item_din_regs);
                we_c.push_back(cyc);
            end
            if (o_acl_clr_list_regs)      begin clr_n++;  clr_c  = cyc; end
            if (o_acl_item_complete_regs) begin cmp_n++;  cmp_c  = cyc; end
            if (o_cfg_done)               begin done_n++; done_c = cyc; end
            if (o_cfg_err)                begin err_n++;  err_c  = cyc; end
            if (o_cfg_busy) begin
                if ({o_acl_port_sel, o_acl_item_sel_regs, o_acl_item_rslt_regs} !== {e_port, e_item, e_rslt})
                    sel_bad++;
            end else if ({o_acl_port_sel, o_acl_item_sel_regs, o_acl_item_rslt_regs} !== 25'd0) begin
                sel_bad++;
            end
        end
    end

    task automatic clear_logs();
        we_a.delete(); we_d.delete(); we_c.delete(); hs_c.delete();
        clr_n = 0; cmp_n = 0; done_n = 0; err_n = 0; sel_bad = 0;
        clr_c = -1; cmp_c = -1; done_c = -1; err_c = -1;
        rdy_first = -1; rdy_rise = -1;
    endtask

    // mode: 0 continuous valid, 1 toggling, 2 random.
    // rmode: 0 ready always high, 1 high 5 cycles after clear, 2 never.
    task automatic drive_op(input logic c, input int l, input logic [3:0] p, input logic [4:0] it,
                            input logic [15:0] rs, input int mode, input int rmode);
        int idx, t, t2, v;
        bit tog;
        @(negedge clk);
        clear_logs();
        while (byte_q.size() < l) byte_q.push_back(8'($urandom));
        exp_q = byte_q;
        byte_q.delete();
        e_port = p; e_item = it; e_rslt = rs;
        cfg_port = p; cfg_item = it; cfg_rslt = rs; cfg_len = 7'(l); cfg_clr = c;
        rdy = (rmode == 0);
        start = 1'b1;
        s0 = cyc;
        @(negedge clk);
        start = 1'b0;
        fork
            begin
                if (rmode == 1) begin
                    t2 = 0;
                    while (clr_n == 0 && t2 < 50) begin @(negedge clk); t2++; end
                    repeat (5) @(negedge clk);
                    rdy = 1'b1;
                    rdy_rise = cyc;
                end
            end
            begin
                idx = 0; t = 0; tog = 1'b1;
                while (idx < l && err_n == 0 && t < 500) begin
                    v = (mode == 0) ? 1 : (mode == 1) ? int'(tog) : int'($urandom_range(0, 1));
                    tog = !tog;
                    valid = (v != 0);
                    byte_d = (v != 0) ? exp_q[idx] : 8'($urandom);
                    if (o_cfg_byte_ready && rdy_first < 0) rdy_first = cyc;
                    if (v != 0 && o_cfg_byte_ready) begin hs_c.push_back(cyc); idx++; end
                    @(negedge clk);
                    t++;
                end
                valid = 1'b0;
                ready_after = o_cfg_byte_ready;
            end
        join
        t = 0;
        while (done_n == 0 && err_n == 0 && t < 100) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({o_cfg_busy, o_cfg_done, o_cfg_err, o_cfg_byte_ready, o_acl_port_sel, o_acl_clr_list_regs,
             o_acl_item_sel_regs, o_acl_item_waddr_regs, o_acl_item_din_regs, o_acl_item_we_regs,
             o_acl_item_rslt_regs, o_acl_item_complete_regs} !== 52'd0)
            $display("FAIL reset_outputs: got nonzero want all zero");
        else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({o_cfg_busy, o_cfg_byte_ready} !== 2'b00)
            $display("FAIL idle_after_reset: got %b want 00", {o_cfg_busy, o_cfg_byte_ready});
        else n_pass++;
    endtask

    task automatic test_basic();
        int bad;
        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        drive_op(1'b0, 4, 4'b0010, 5'd3, 16'h0A11, 0, 0);
        bad = 0;
        for (int i = 0; i < we_a.size(); i++)
            if (we_a[i] !== 6'(i) || we_d[i] !== exp_q[i] || we_c[i] !== s0 + 4 + i) bad++;
        n_chk++;
        if (we_a.size() != 4 || bad != 0)
            $display("FAIL basic_writes: got %0d writes %0d bad want 4 writes 0 bad", we_a.size(), bad);
        else n_pass++;
        n_chk++;
        if (cmp_n != 1 || cmp_c != s0 + 8)
            $display("FAIL basic_complete: got n=%0d cyc=%0d want n=1 cyc=%0d", cmp_n, cmp_c, s0 + 8);
        else n_pass++;
        n_chk++;
        if (done_n != 1 || done_c != cmp_c + 1)
            $display("FAIL basic_done: got n=%0d cyc=%0d want n=1 cyc=%0d", done_n, done_c, cmp_c + 1);
        else n_pass++;
        n_chk++;
        if (clr_n != 0 || err_n != 0)
            $display("FAIL basic_no_clr_err: got clr=%0d err=%0d want 0 0", clr_n, err_n);
        else n_pass++;
        n_chk++;
        if (sel_bad != 0) $display("FAIL basic_sel_stable: got %0d bad cycles want 0", sel_bad);
        else n_pass++;
        n_chk++;
        if (ready_after !== 1'b0 || o_cfg_busy !== 1'b0)
            $display("FAIL basic_ready_busy_drop: got ready=%b busy=%b want 0 0", ready_after, o_cfg_busy);
        else n_pass++;
    endtask

    task automatic test_clr_wait();
        int l, bad;
        l = $urandom_range(1, 16);
        drive_op(1'b1, l, 4'b1000, 5'd17, 16'hBEEF, 0, 1);
        n_chk++;
        if (clr_n != 1 || clr_c != s0 + 2)
            $display("FAIL clr_pulse: got n=%0d cyc=%0d want n=1 cyc=%0d", clr_n, clr_c, s0 + 2);
        else n_pass++;
        n_chk++;
        if (we_c.size() == 0 || we_c[0] != rdy_rise + 2)
            $display("FAIL clr_first_we: got %0d want %0d", (we_c.size() > 0) ? we_c[0] : -1, rdy_rise + 2);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < we_a.size(); i++) if (we_a[i] !== 6'(i) || we_d[i] !== exp_q[i]) bad++;
        n_chk++;
        if (we_a.size() != l || bad != 0 || done_n != 1 || sel_bad != 0)
            $display("FAIL clr_writes: got %0d writes %0d bad done=%0d want %0d 0 1", we_a.size(), bad, done_n, l);
        else n_pass++;
    endtask

    task automatic test_len64();
        int bad, last;
        drive_op(1'b0, 64, 4'b0101, 5'd31, 16'h7F02, 1, 0);
        bad = 0;
        for (int i = 0; i < we_a.size(); i++)
            if (we_a[i] !== 6'(i) || we_d[i] !== exp_q[i] || i >= hs_c.size() || we_c[i] != hs_c[i] + 1) bad++;
        n_chk++;
        if (we_a.size() != 64 || bad != 0)
            $display("FAIL len64_writes: got %0d writes %0d bad want 64 0", we_a.size(), bad);
        else n_pass++;
        last = (we_c.size() > 0) ? we_c[we_c.size() - 1] : -100;
        n_chk++;
        if (cmp_n != 1 || cmp_c != last + 1 || done_c != last + 2)
            $display("FAIL len64_complete: got cmp=%0d done=%0d want %0d %0d", cmp_c, done_c, last + 1, last + 2);
        else n_pass++;
        n_chk++;
        if (ready_after !== 1'b0) $display("FAIL len64_ready_drop: got %b want 0", ready_after);
        else n_pass++;
    endtask

    task automatic test_bad_len();
        int lens[2] = '{0, 65};
        foreach (lens[k]) begin
            drive_op(1'b1, lens[k], 4'b0011, 5'd4, 16'h0102, 0, 0);
            n_chk++;
            if (err_n != 1 || err_c != s0 + 2)
                $display("FAIL bad_len_err len=%0d: got n=%0d cyc=%0d want n=1 cyc=%0d", lens[k], err_n, err_c, s0 + 2);
            else n_pass++;
            n_chk++;
            if (clr_n + we_a.size() + cmp_n + done_n != 0 || o_cfg_busy !== 1'b0)
                $display("FAIL bad_len_quiet len=%0d: got activity=%0d busy=%b want 0 0", lens[k],
                         clr_n + we_a.size() + cmp_n + done_n, o_cfg_busy);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        drive_op(1'b0, 5, 4'b0100, 5'd8, 16'h5555, 0, 2);
        n_chk++;
        if (err_n != 1 || err_c != s0 + 18)
            $display("FAIL timeout_err: got n=%0d cyc=%0d want n=1 cyc=%0d", err_n, err_c, s0 + 18);
        else n_pass++;
        n_chk++;
        if (we_a.size() + cmp_n + done_n != 0)
            $display("FAIL timeout_quiet: got activity=%0d want 0", we_a.size() + cmp_n + done_n);
        else n_pass++;
        drive_op(1'b0, 5, 4'b0100, 5'd8, 16'h5555, 0, 0);
        n_chk++;
        if (done_n != 1 || we_a.size() != 5 || err_n != 0)
            $display("FAIL timeout_recover: got done=%0d writes=%0d err=%0d want 1 5 0", done_n, we_a.size(), err_n);
        else n_pass++;
    endtask

    task automatic test_random();
        int l, bad, last;
        logic c;
        for (int it = 0; it < 6; it++) begin
            c = 1'($urandom_range(0, 1));
            l = $urandom_range(1, 64);
            drive_op(c, l, 4'($urandom), 5'($urandom), 16'($urandom), 2, 0);
            bad = 0;
            for (int i = 0; i < we_a.size(); i++)
                if (we_a[i] !== 6'(i) || we_d[i] !== exp_q[i] || i >= hs_c.size() || we_c[i] != hs_c[i] + 1) bad++;
            n_chk++;
            if (we_a.size() != l || bad != 0)
                $display("FAIL rand%0d_writes: got %0d writes %0d bad want %0d 0", it, we_a.size(), bad, l);
            else n_pass++;
            n_chk++;
            if (rdy_first != s0 + (c ? 5 : 3) || clr_n != int'(c))
                $display("FAIL rand%0d_start: got ready_cyc=%0d clr=%0d want %0d %0d", it, rdy_first, clr_n,
                         s0 + (c ? 5 : 3), c);
            else n_pass++;
            last = (we_c.size() > 0) ? we_c[we_c.size() - 1] : -100;
            n_chk++;
            if (cmp_n != 1 || cmp_c != last + 1 || done_n != 1 || done_c != last + 2 || sel_bad != 0)
                $display("FAIL rand%0d_end: got cmp=%0d done=%0d sel_bad=%0d want %0d %0d 0", it, cmp_c, done_c,
                         sel_bad, last + 1, last + 2);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int idx, t, n_we;
        @(negedge clk);
        clear_logs();
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'($urandom));
        e_port = 4'b0101; e_item = 5'd9; e_rslt = 16'h1234;
        cfg_port = e_port; cfg_item = e_item; cfg_rslt = e_rslt; cfg_len = 7'd8; cfg_clr = 1'b0;
        rdy = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0; t = 0;
        while (we_a.size() < 2 && t < 50) begin
            valid = 1'b1;
            byte_d = exp_q[(idx < 8) ? idx : 7];
            if (o_cfg_byte_ready && idx < 8) idx++;
            @(negedge clk);
            t++;
        end
        valid = 1'b0;
        cfg_port = 4'b1111; cfg_item = 5'd30; cfg_len = 7'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if ({o_cfg_busy, o_cfg_done, o_cfg_err, o_cfg_byte_ready, o_acl_port_sel, o_acl_clr_list_regs,
             o_acl_item_sel_regs, o_acl_item_waddr_regs, o_acl_item_din_regs, o_acl_item_we_regs,
             o_acl_item_rslt_regs, o_acl_item_complete_regs} !== 52'd0)
            $display("FAIL midreset_outputs: got nonzero want all zero");
        else n_pass++;
        n_we = we_a.size();
        repeat (12) @(negedge clk);
        n_chk++;
        if (cmp_n + done_n != 0 || we_a.size() != n_we || n_we < 2 || sel_bad != 0)
            $display("FAIL midreset_quiet: got cmp+done=%0d writes=%0d->%0d sel_bad=%0d want 0 same>=2 0",
                     cmp_n + done_n, n_we, we_a.size(), sel_bad);
        else n_pass++;
        drive_op(1'b0, 8, 4'b0110, 5'd12, 16'hA5A5, 0, 0);
        n_chk++;
        if (done_n != 1 || we_a.size() != 8 || cmp_n != 1)
            $display("FAIL midreset_rerun: got done=%0d writes=%0d cmp=%0d want 1 8 1", done_n, we_a.size(), cmp_n);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1);
    end

    initial begin
        clear_logs();
        test_reset();
        test_basic();
        test_clr_wait();
        test_len64();
        test_bad_len();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
